// File: rtl/irq_grant_responder_pkg.sv
// Shared types, defaults and helpers for the interrupt grant responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_grant_responder_pkg;

  localparam int NUM_CH_DEF  = 9;
  localparam int CODE_W_DEF  = 4;
  localparam int TIMEOUT_DEF = 255;
  localparam int GAP_DEF     = 2;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACK     = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  // A code is legal when it names an existing channel.
  function automatic logic code_is_legal(input int code, input int num_ch);
    return (code < num_ch);
  endfunction

endpackage

// File: rtl/irq_grant_responder_if.sv
// Encoder-to-responder grant bus plus the acknowledge/status signals back to the channels.
// Latency: n/a (wiring only).
// Backpressure: none; the responder simply ignores grants while busy.
interface irq_grant_responder_if
  import irq_grant_responder_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CODE_W = CODE_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              grant_valid;
  logic [CODE_W-1:0] grant_code;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] ack;
  logic              busy;
  logic [CODE_W-1:0] active_ch;
  logic              err_code;
  logic              timeout;
  logic [CNT_W-1:0]  svc_cnt;

  // Encoder / channel side: drives grants and request lines, observes the ack.
  modport master (
    output grant_valid, grant_code, req, ch_mask,
    input  ack, busy, active_ch, err_code, timeout, svc_cnt
  );

  // Responder side.
  modport slave (
    input  grant_valid, grant_code, req, ch_mask,
    output ack, busy, active_ch, err_code, timeout, svc_cnt
  );
endinterface

// File: rtl/irq_grant_responder_onehot_dec.sv
// Binary channel code to one-hot channel vector; illegal codes decode to all zeros.
// Latency: combinational.
// Backpressure: none.
module irq_grant_responder_onehot_dec #(
  parameter int NUM_CH = 9,
  parameter int CODE_W = 4
) (
  input  logic [CODE_W-1:0] code_i,
  output logic [NUM_CH-1:0] onehot_o
);

  // Compare against every legal index; codes >= NUM_CH match nothing and yield zero.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      onehot_o[i] = (code_i == CODE_W'(i));
    end
  end

endmodule

// File: rtl/irq_grant_responder.sv
// Accepts an encoded interrupt winner, returns a registered one-hot ack until request drop or timeout.
// Latency: ack 1 clock after the grant is sampled in IDLE; GAP-cycle re-arm gap after each release.
// Backpressure: grants arriving outside IDLE (or for masked/illegal codes) are dropped, never queued.
module irq_grant_responder
  import irq_grant_responder_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int CODE_W  = CODE_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int GAP     = GAP_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic                   clk,
  input logic                   rst,
  irq_grant_responder_if.slave  bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP + 1);

  state_e            state_q;
  logic [NUM_CH-1:0] ack_q;
  logic              busy_q;
  logic [CODE_W-1:0] active_ch_q;
  logic              err_code_q;
  logic              timeout_q;
  logic [CNT_W-1:0]  svc_cnt_q;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic [NUM_CH-1:0] grant_onehot;
  logic              grant_legal;
  logic              grant_masked;
  logic              req_live;

  irq_grant_responder_onehot_dec #(
    .NUM_CH (NUM_CH),
    .CODE_W (CODE_W)
  ) u_dec (
    .code_i   (bus.grant_code),
    .onehot_o (grant_onehot)
  );

  assign grant_legal  = code_is_legal(32'(bus.grant_code), NUM_CH);
  assign grant_masked = |(grant_onehot & bus.ch_mask);
  // ack_q is one-hot on the serviced channel, so this picks req[active_ch].
  assign req_live     = |(bus.req & ack_q);
  // tmo_cnt_d is the number of ACK cycles completed once this edge lands.
  assign tmo_cnt_d    = tmo_cnt_q + TMO_W'(1);
  assign gap_cnt_d    = gap_cnt_q + GAP_W'(1);

  // Service FSM with all outputs registered; a request drop wins over a simultaneous timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      active_ch_q <= '0;
      err_code_q  <= 1'b0;
      timeout_q   <= 1'b0;
      svc_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      err_code_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.grant_valid) begin
            if (!grant_legal) begin
              err_code_q <= 1'b1;
            end else if (!grant_masked) begin
              state_q     <= S_ACK;
              ack_q       <= grant_onehot;
              busy_q      <= 1'b1;
              active_ch_q <= bus.grant_code;
              tmo_cnt_q   <= '0;
            end
          end
        end
        S_ACK: begin
          if (!req_live || (tmo_cnt_d == TMO_W'(TIMEOUT))) begin
            timeout_q <= req_live;
            state_q   <= S_RELEASE;
            ack_q     <= '0;
            gap_cnt_q <= '0;
            svc_cnt_q <= svc_cnt_q + CNT_W'(1);
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
          end
        end
        S_RELEASE: begin
          if (gap_cnt_d == GAP_W'(GAP)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ack_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.active_ch = active_ch_q;
  assign bus.err_code  = err_code_q;
  assign bus.timeout   = timeout_q;
  assign bus.svc_cnt   = svc_cnt_q;

endmodule
